forwarding_pipeline_tracker: RTL

Back end of the hazard/forwarding path in the 5-stage pipeline. It holds the ID→EX→MEM→WB destination-tracking registers: destination register, RF write enable and load flag. These feed the hazard/forwarding unit as `ex_/mem_/wb_destination`, `*_rf_enable` and `ex_load_instruction`. It also consumes that unit's `pa_selector`, `pb_selector` and `nop_signal` outputs to insert bubbles and to steer forwarded operand values into EX.

---
 rtl/pipeline_pkg.sv | 9 +
 rtl/dest_stage_reg.sv | 20 ++
 rtl/forwarding_pipeline_tracker.sv | 70 +++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared forwarding-select, register and stage-entry constants
package pipeline_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    localparam logic [4:0] REG_X0  = 5'd0;
    localparam int         STAGE_W = 7;
endpackage

// File: rtl/dest_stage_reg.sv
// dest_stage_reg: one {dest, rf_en, load} tracking register with bubble insertion
module dest_stage_reg
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               bubble,
    input  logic [STAGE_W-1:0] entry_in,
    output logic [STAGE_W-1:0] entry_out
);
    logic [STAGE_W-1:0] entry_d, entry_q;

    // a bubble replaces the incoming entry with an all-zero (no-write) entry
    always_comb entry_d = bubble ? '0 : entry_in;

    // stage register; reset discards whatever is in flight
    always_ff @(posedge clk) entry_q <= reset ? '0 : entry_d;

    assign entry_out = entry_q;
endmodule

// File: rtl/forwarding_pipeline_tracker.sv
// forwarding_pipeline_tracker: EX/MEM/WB destination tracking, bubble count and operand forwarding mux
module forwarding_pipeline_tracker
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rd,
    input  logic              id_rf_enable,
    input  logic              id_load_instruction,
    input  logic              id_valid,
    input  logic              nop_signal,
    input  logic              flush,
    input  logic [1:0]        pa_selector,
    input  logic [1:0]        pb_selector,
    input  logic [DATA_W-1:0] id_pa,
    input  logic [DATA_W-1:0] id_pb,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [4:0]        ex_destination,
    output logic [4:0]        mem_destination,
    output logic [4:0]        wb_destination,
    output logic              ex_rf_enable,
    output logic              mem_rf_enable,
    output logic              wb_rf_enable,
    output logic              ex_load_instruction,
    output logic [DATA_W-1:0] pa_operand,
    output logic [DATA_W-1:0] pb_operand,
    output logic [CNT_W-1:0]  bubble_count
);
    logic [STAGE_W-1:0] id_entry, ex_entry, mem_entry, wb_entry;
    logic               ex_bubble, counted;
    logic [CNT_W-1:0]   bubble_count_d, bubble_count_q;
    logic               unused_wb_load;

    // x0 is tracked as a non-writer so it can never be forwarded
    always_comb begin
        id_entry  = {id_rd, id_rf_enable && (id_rd != REG_X0), id_load_instruction};
        ex_bubble = nop_signal | flush | ~id_valid;
        counted   = nop_signal | flush;
    end

    dest_stage_reg u_ex  (.clk(clk), .reset(reset), .bubble(ex_bubble), .entry_in(id_entry),  .entry_out(ex_entry));
    dest_stage_reg u_mem (.clk(clk), .reset(reset), .bubble(1'b0),      .entry_in(ex_entry),  .entry_out(mem_entry));
    dest_stage_reg u_wb  (.clk(clk), .reset(reset), .bubble(1'b0),      .entry_in(mem_entry), .entry_out(wb_entry));

    // saturating count of hazard/flush bubbles; idle ID slots are not counted
    always_comb bubble_count_d = (counted && bubble_count_q != '1) ? bubble_count_q + 1'b1 : bubble_count_q;

    // bubble counter register
    always_ff @(posedge clk) bubble_count_q <= reset ? '0 : bubble_count_d;

    // operand forwarding mux, same selection for A and B
    always_comb begin
        pa_operand = pa_selector == FWD_EX  ? ex_result  :
                     pa_selector == FWD_MEM ? mem_result :
                     pa_selector == FWD_WB  ? wb_result  : id_pa;
        pb_operand = pb_selector == FWD_EX  ? ex_result  :
                     pb_selector == FWD_MEM ? mem_result :
                     pb_selector == FWD_WB  ? wb_result  : id_pb;
    end

    assign {ex_destination, ex_rf_enable, ex_load_instruction} = ex_entry;
    assign {mem_destination, mem_rf_enable} = mem_entry[STAGE_W-1:1];
    assign {wb_destination, wb_rf_enable, unused_wb_load} = wb_entry;
    assign bubble_count = bubble_count_q;
endmodule
